// File: rtl/ul_re_pack_to_fifo.sv
// ul_re_pack_to_fifo: packs per-strobe RE pairs and decimated noise samples into 128-bit IQ and noise FIFO words.
module ul_re_pack_to_fifo #(
  parameter int SW = 16,
  parameter int CW = 16
) (
  input  logic            i_core_clk,
  input  logic            i_rx_rstn,
  input  logic            i_rx_fsm_rstn,
  input  logic            i_user_start,
  input  logic [CW-1:0]   i_cur_user_re_amounts,
  input  logic [CW-1:0]   i_user_iq_noise_rate,
  input  logic            i_data_strobe,
  input  logic [SW-1:0]   i_re0_data_i,
  input  logic [SW-1:0]   i_re0_data_q,
  input  logic [SW-1:0]   i_re1_data_i,
  input  logic [SW-1:0]   i_re1_data_q,
  input  logic [SW-1:0]   i_noise_data,
  output logic            o_in_ready,
  input  logic            i_iq_fifo_full,
  output logic            o_iq_fifo_wr_en,
  output logic [8*SW-1:0] o_iq_fifo_wdata,
  input  logic            i_noise_fifo_full,
  output logic            o_noise_fifo_wr_en,
  output logic [8*SW-1:0] o_noise_fifo_wdata,
  output logic            o_user_done,
  output logic            o_overflow
);
  typedef enum logic [1:0] {IDLE, COLLECT, FLUSH, DONE} state_t;
  typedef struct packed {
    state_t           st;
    logic [CW-1:0]    amt;
    logic [CW-1:0]    intv;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    sub;
    logic             half;
    logic [2:0]       k;
    logic [4*SW-1:0]  iq_acc;
    logic [8*SW-1:0]  nz_acc;
    logic [8*SW-1:0]  iq_wd;
    logic [8*SW-1:0]  nz_wd;
    logic             iq_pend;
    logic             nz_pend;
    logic             iq_we;
    logic             nz_we;
    logic             done;
    logic             ovf;
  } regs_t;
  regs_t r, n;
  logic take;
  logic [CW-1:0] cnt_nx, sub_nx, half_rate;
  logic [4*SW-1:0] pair;
  assign o_in_ready = (r.st == COLLECT) && !r.iq_pend && !r.nz_pend && !i_iq_fifo_full && !i_noise_fifo_full;
  assign take = i_data_strobe && o_in_ready;
  assign pair = {i_re1_data_q, i_re1_data_i, i_re0_data_q, i_re0_data_i};
  assign cnt_nx = (r.cnt > ({CW{1'b1}} - CW'(2))) ? {CW{1'b1}} : r.cnt + CW'(2);
  assign sub_nx = (r.sub + CW'(1) >= r.intv) ? '0 : r.sub + CW'(1);
  assign half_rate = i_user_iq_noise_rate >> 1;
  always_comb begin
    n = r;
    n.done = 1'b0;
    n.ovf = r.ovf | (i_data_strobe & ~o_in_ready);
    if (r.iq_we && !i_iq_fifo_full) n.iq_pend = 1'b0;
    if (r.nz_we && !i_noise_fifo_full) n.nz_pend = 1'b0;
    case (r.st)
      IDLE: if (i_user_start) begin
        n = '0;
        n.st = COLLECT;
        n.amt = i_cur_user_re_amounts;
        n.intv = (half_rate == '0) ? CW'(1) : half_rate;
      end
      COLLECT: if (take) begin
        n.cnt = cnt_nx;
        n.half = ~r.half;
        if (!r.half) n.iq_acc = pair;
        else begin
          n.iq_wd = {pair, r.iq_acc};
          n.iq_pend = 1'b1;
        end
        n.sub = sub_nx;
        if (r.sub == '0) begin
          n.k = r.k + 3'd1;
          if (r.k == 3'd7) begin
            n.nz_wd = {i_noise_data, r.nz_acc[7*SW-1:0]};
            n.nz_acc = '0;
            n.nz_pend = 1'b1;
          end else n.nz_acc[SW*r.k +: SW] = i_noise_data;
        end
        if (cnt_nx >= r.amt) n.st = FLUSH;
      end
      FLUSH: begin
        if (r.half) begin
          n.iq_wd = {{4*SW{1'b0}}, r.iq_acc};
          n.iq_pend = 1'b1;
          n.half = 1'b0;
        end
        if (r.k != '0) begin
          n.nz_wd = r.nz_acc;
          n.nz_acc = '0;
          n.nz_pend = 1'b1;
          n.k = '0;
        end
        if (!r.half && r.k == '0 && !r.iq_pend && !r.nz_pend) begin
          n.st = DONE;
          n.done = 1'b1;
        end
      end
      default: n.st = IDLE;
    endcase
    // a write refused by a full FIFO is simply re-issued once it drains; wdata stays put meanwhile
    n.iq_we = n.iq_pend && !i_iq_fifo_full;
    n.nz_we = n.nz_pend && !i_noise_fifo_full;
  end
  always_ff @(posedge i_core_clk or negedge i_rx_rstn)
    if (!i_rx_rstn) r <= '0;
    else r <= i_rx_fsm_rstn ? n : '0;
  assign o_iq_fifo_wr_en = r.iq_we;
  assign o_iq_fifo_wdata = r.iq_wd;
  assign o_noise_fifo_wr_en = r.nz_we;
  assign o_noise_fifo_wdata = r.nz_wd;
  assign o_user_done = r.done;
  assign o_overflow = r.ovf;
endmodule

// File: tb/tb_ul_re_pack_to_fifo.sv
// tb_ul_re_pack_to_fifo: randomized scoreboard bench for the RE/noise FIFO packer.
module tb_ul_re_pack_to_fifo;
  localparam int SW = 16;
  localparam int CW = 16;
  localparam int W = 8 * SW;
  logic clk = 0, rstn = 0, fsm_rstn = 1, start = 0, strobe = 0;
  logic [CW-1:0] amt_in = '0, rate_in = '0;
  logic [SW-1:0] r0i = '0, r0q = '0, r1i = '0, r1q = '0, nz_in = '0;
  logic iq_full = 0, nz_full = 0;
  logic ready, iq_we, nz_we, done, ovf;
  logic [W-1:0] iq_wd, nz_wd;
  ul_re_pack_to_fifo #(.SW(SW), .CW(CW)) dut (
    .i_core_clk(clk), .i_rx_rstn(rstn), .i_rx_fsm_rstn(fsm_rstn), .i_user_start(start),
    .i_cur_user_re_amounts(amt_in), .i_user_iq_noise_rate(rate_in), .i_data_strobe(strobe),
    .i_re0_data_i(r0i), .i_re0_data_q(r0q), .i_re1_data_i(r1i), .i_re1_data_q(r1q),
    .i_noise_data(nz_in), .o_in_ready(ready), .i_iq_fifo_full(iq_full), .o_iq_fifo_wr_en(iq_we),
    .o_iq_fifo_wdata(iq_wd), .i_noise_fifo_full(nz_full), .o_noise_fifo_wr_en(nz_we),
    .o_noise_fifo_wdata(nz_wd), .o_user_done(done), .o_overflow(ovf)
  );
  always #5 clk = ~clk;
  int pass_cnt = 0, chk_cnt = 0, done_seen = 0, iq_writes = 0, nz_writes = 0;
  logic [W-1:0] iq_q[$], nz_q[$];
  logic [4*SW-1:0] pr[$];
  logic [SW-1:0] nzs[$];
  bit rnd_full = 0, gaps = 0;
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask
  task automatic unexpected(input string name, input logic [W-1:0] act);
    chk_cnt++;
    $display("FAIL %s: write of %h, expected no write", name, act);
  endtask
  initial forever begin
    @(negedge clk); #1;
    if (iq_we && !iq_full) begin
      iq_writes++;
      if (iq_q.size() == 0) unexpected("iq_extra", iq_wd);
      else check("iq_word", iq_wd, iq_q.pop_front());
    end
    if (nz_we && !nz_full) begin
      nz_writes++;
      if (nz_q.size() == 0) unexpected("nz_extra", nz_wd);
      else check("nz_word", nz_wd, nz_q.pop_front());
    end
    if (done) done_seen++;
  end
  // reference: IQ words are consecutive strobe pairs; noise keeps every interval-th strobe, 8 per word, zero padded
  task automatic start_user(input int amt, input int rate);
    int ns, iv, kept;
    logic [W-1:0] w;
    ns = (amt + 1) / 2;
    iv = (rate / 2 < 1) ? 1 : rate / 2;
    pr.delete(); nzs.delete();
    for (int i = 0; i < ns; i++) begin
      pr.push_back({$urandom(), $urandom()});
      nzs.push_back(SW'($urandom()));
    end
    for (int i = 0; i < ns; i += 2) iq_q.push_back({(i + 1 < ns) ? pr[i+1] : 64'd0, pr[i]});
    kept = 0; w = '0;
    for (int i = 0; i < ns; i++) if (i % iv == 0) begin
      w[SW*kept +: SW] = nzs[i];
      kept++;
      if (kept == 8) begin nz_q.push_back(w); w = '0; kept = 0; end
    end
    if (kept != 0) nz_q.push_back(w);
    @(negedge clk);
    amt_in = CW'(amt); rate_in = CW'(rate); start = 1;
    @(negedge clk);
    start = 0;
  endtask
  task automatic strobe_one(input int idx);
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      strobe = 0;
      if (rnd_full) begin
        iq_full = ($urandom_range(0, 3) == 0);
        nz_full = ($urandom_range(0, 3) == 0);
      end
      #1;
      if (ready && !(gaps && $urandom_range(0, 2) == 0)) begin
        {r1q, r1i, r0q, r0i} = pr[idx];
        nz_in = nzs[idx];
        strobe = 1;
        return;
      end
    end
    check("ready_timeout", 0, 1);
  endtask
  task automatic finish_user();
    int d0;
    @(negedge clk);
    strobe = 0; rnd_full = 0; iq_full = 0; nz_full = 0;
    d0 = done_seen;
    for (int c = 0; c < 300 && done_seen == d0; c++) @(posedge clk);
    repeat (4) @(posedge clk);
    check("user_done_once", done_seen - d0, 1);
    check("iq_drained", iq_q.size(), 0);
    check("nz_drained", nz_q.size(), 0);
    iq_q.delete(); nz_q.delete();
  endtask
  task automatic run_user(input int amt, input int rate);
    start_user(amt, rate);
    for (int i = 0; i < pr.size(); i++) strobe_one(i);
    finish_user();
  endtask
  task automatic check_idle_outputs(input string name);
    check({name, "_we"}, {iq_we, nz_we, done, ovf, ready}, 0);
    check({name, "_iq_wd"}, iq_wd, 0);
    check({name, "_nz_wd"}, nz_wd, 0);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end
  initial begin
    int w0, d0;
    logic [W-1:0] held;
    repeat (3) @(negedge clk);
    #1 check_idle_outputs("reset");
    rstn = 1;
    run_user(16, 4);
    run_user(32, 2);
    run_user(6, 6);
    // full FIFO holds the completed IQ word
    start_user(8, 2);
    strobe_one(0);
    strobe_one(1);
    @(posedge clk); #1;
    strobe = 0; iq_full = 1;
    held = iq_wd;
    w0 = iq_writes;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      check("full_ready_low", ready, 0);
      check("full_wdata_held", iq_wd, held);
      if (c > 0) check("full_we_low", iq_we, 0);
    end
    iq_full = 0;
    repeat (3) @(posedge clk);
    #1 check("full_one_write", iq_writes - w0, 1);
    strobe_one(2);
    strobe_one(3);
    finish_user();
    // a strobe while not ready sets sticky overflow and is dropped
    start_user(8, 4);
    strobe_one(0);
    @(negedge clk);
    strobe = 0; iq_full = 1;
    #1 check("ovf_ready_low", ready, 0);
    {r1q, r1i, r0q, r0i} = {$urandom(), $urandom()};
    strobe = 1;
    @(negedge clk);
    strobe = 0; iq_full = 0;
    #1 check("ovf_set", ovf, 1);
    for (int i = 1; i < 4; i++) strobe_one(i);
    finish_user();
    check("ovf_sticky", ovf, 1);
    // async reset mid-collect with half word and three noise lanes
    start_user(16, 2);
    #1 check("ovf_cleared", ovf, 0);
    for (int i = 0; i < 3; i++) strobe_one(i);
    @(negedge clk);
    strobe = 0;
    repeat (3) @(posedge clk);
    iq_q.delete(); nz_q.delete();
    w0 = iq_writes + nz_writes; d0 = done_seen;
    @(negedge clk);
    rstn = 0;
    #1 check_idle_outputs("async_rst");
    repeat (2) @(negedge clk);
    rstn = 1;
    repeat (10) @(posedge clk);
    #1 check("async_rst_no_writes", iq_writes + nz_writes - w0, 0);
    check("async_rst_no_done", done_seen - d0, 0);
    check("async_rst_idle", ready, 0);
    // synchronous FSM clear, same effect
    start_user(16, 6);
    for (int i = 0; i < 5; i++) strobe_one(i);
    @(negedge clk);
    strobe = 0;
    repeat (3) @(posedge clk);
    iq_q.delete(); nz_q.delete();
    w0 = iq_writes + nz_writes; d0 = done_seen;
    @(negedge clk);
    fsm_rstn = 0;
    @(negedge clk); #1;
    check_idle_outputs("fsm_clr");
    fsm_rstn = 1;
    repeat (10) @(posedge clk);
    #1 check("fsm_clr_no_writes", iq_writes + nz_writes - w0, 0);
    check("fsm_clr_no_done", done_seen - d0, 0);
    run_user(7, 1);
    run_user(2, 0);
    gaps = 1;
    for (int u = 0; u < 8; u++) begin
      rnd_full = 1;
      run_user(2 * $urandom_range(1, 24), $urandom_range(0, 9));
    end
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
